alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU bgn/rdy handshake. Accepts one instruction at a time and reads its operands from an internal 8x16 register file. Issues the operation to the ALU, waits for completion, then writes the results back and latches the ALU flags. It sits between instruction fetch/decode and the ALU, and owns the architectural registers.

Parameters:
TIMEOUT, 64, max WAIT cycles for alu_rdy before aborting (>=2)
TW, 7, width of timeout counter (2^TW > TIMEOUT)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept (== state IDLE)
instr  in  16  [15:11] opcode, [10:8] rd, [7:5] rs, [4] use_imm, [3:0] imm (zero-extended)
host_wr  in  1  host register write, honoured only in IDLE
host_addr  in  3  host write/read address
host_wdata  in  16  host write data
host_rdata  out  16  combinational R[host_addr]
alu_bgn  out  1  one-cycle start pulse to ALU
alu_opcode  out  6  {1'b0, opcode}, held from ISSUE through WAIT
alu_a, alu_b  out  16  operands, held from ISSUE through WAIT
alu_acc1, alu_acc2  in  16  ALU results
alu_zero, alu_negative, alu_carry, alu_overflow  in  1  ALU flags
alu_rdy  in  1  ALU done (level; stays high between ops)
flags  out  4  {Z,N,C,V} latched at completion
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in WB
err  out  1  sticky: timeout or illegal opcode; cleared only by rst

Behaviour:
- Reset (rst high at clk edge): state=IDLE; R[0..7]=0; flags=0; alu_bgn=0; alu_opcode=0; alu_a=alu_b=0; done=0; err=0; timeout counter=0. rst mid-operation aborts at once: no writeback, no done.
- Legal opcodes: ADD, SUB, LSR, LSL, RSR, RSL, MOV, MUL, DIV, MOD, AND, OR, XOR, NOT, CMP, TST, INC, DEC, NOP (01..12 hex and 1F).
- IDLE: instr_ready=1.
  - host_wr writes R[host_addr]=host_wdata.
  - On instr_valid: latch instr.
    - Legal opcode -> ISSUE.
    - Illegal opcode -> set err, stay IDLE, no ALU activity.
  - NOP is accepted but skips the ALU: next state WB with no writeback, done pulses, flags unchanged.
- Same-cycle host_wr and accept: the host write takes effect; ISSUE reads the new value.
- ISSUE (1 cycle):
  - alu_bgn=1; alu_a=R[rd]; alu_b = use_imm ? {12'b0,imm} : R[rs]; alu_opcode driven.
  - Clear seen_low and counter. Next: WAIT.
- WAIT:
  - alu_bgn=0; operands and opcode held stable.
  - Set seen_low when alu_rdy==0.
  - Completion = alu_rdy==1 with seen_low already set. A stale high rdy from the previous op is never taken as completion.
  - On completion: capture acc1, acc2 and flags -> WB.
  - Counter increments every WAIT cycle. Reaching TIMEOUT without completion: set err, alu_opcode=0, go to IDLE, no writeback, no done.
- WB (1 cycle): done=1; flags <= captured flags (not for NOP). Writeback:
  - MUL: R[rd]=acc1, R[(rd+1) mod 8]=acc2; both written in the same cycle; rd=7 wraps to R[0].
  - DIV, MOD, ADD and other arithmetic/logic ops: R[rd]=acc1.
  - CMP, TST, NOP: no register write.
  - Then alu_opcode=0 and next state IDLE.
- Latency: accept at edge T; bgn high in cycle T+1. If completion is seen in cycle T+k, done is high in T+k+1 and instr_ready is high in T+k+2.
- host_wr outside IDLE is ignored. host_rdata always reflects current contents.

Test Plan:
- Reset, then host writes R1=0x0005, R2=0x0003. Issue ADD rd=1 rs=2. ALU model drops rdy 1 cycle after bgn and raises it 3 cycles later with acc1=0x0008 -> exactly one bgn pulse; alu_a=5, alu_b=3; done once; R1=0x0008; busy low after.
- MUL rd=7, R7=0x0100, imm=0x8, use_imm=1. Model returns acc1=0x0800, acc2=0x0000 -> R7=0x0800, R0=0x0000; other registers unchanged.
- CMP rd=1 rs=2 with model flags Z=1,C=0 -> R1 unchanged; flags=4'b1000; done pulses.
- Stale rdy: model holds rdy high and never drops it -> no completion; after TIMEOUT=64 WAIT cycles err=1, state IDLE, no done, registers unchanged.
- Illegal opcode 5'b10101 -> err=1; alu_bgn never asserted; instr_ready stays 1.
- Assert rst during WAIT -> next cycle: all registers 0, busy=0, alu_bgn=0; a later rdy from the model causes no writeback.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// ALU issue bus: start pulse, operands and opcode out; results, flags and rdy back.
interface alu_issue_ctrl_if;
  logic        alu_bgn;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_acc1, alu_acc2;
  logic        alu_zero, alu_negative, alu_carry, alu_overflow;
  logic        alu_rdy;

  modport master (
    output alu_bgn, alu_opcode, alu_a, alu_b,
    input  alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow, alu_rdy
  );
  modport slave (
    input  alu_bgn, alu_opcode, alu_a, alu_b,
    output alu_acc1, alu_acc2, alu_zero, alu_negative, alu_carry, alu_overflow, alu_rdy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: owns the 8x16 register file, issues one op at a time
// over the bgn/rdy handshake, writes results back and latches flags.
module alu_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [15:0]            instr,
  input  logic                   host_wr,
  input  logic [2:0]             host_addr,
  input  logic [15:0]            host_wdata,
  output logic [15:0]            host_rdata,
  alu_issue_ctrl_if.master       alu,
  output logic [3:0]             flags,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  localparam logic [4:0] OP_MUL = 5'h08;
  localparam logic [4:0] OP_CMP = 5'h0F;
  localparam logic [4:0] OP_TST = 5'h10;
  localparam logic [4:0] OP_NOP = 5'h1F;

  logic [1:0]         state;
  logic [7:0][15:0]   rf;
  logic [4:0]         ir_op;
  logic [2:0]         ir_rd;
  logic               seen_low;
  logic [TW-1:0]      cnt;
  logic [15:0]        cap_acc1, cap_acc2;
  logic [3:0]         cap_flags;

  logic [4:0]  op;
  logic [2:0]  rd, rs;
  logic        legal;
  logic [15:0] rd_val, rs_val;

  always_comb begin
    op    = instr[15:11];
    rd    = instr[10:8];
    rs    = instr[7:5];
    legal = ((op >= 5'h01) && (op <= 5'h12)) || (op == OP_NOP);
    // A host write landing in the accept cycle must be visible to the operands.
    rd_val = (host_wr && host_addr == rd) ? host_wdata : rf[rd];
    rs_val = (host_wr && host_addr == rs) ? host_wdata : rf[rs];
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == WB);
  assign host_rdata  = rf[host_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rf             <= '0;
      flags          <= '0;
      err            <= 1'b0;
      alu.alu_bgn    <= 1'b0;
      alu.alu_opcode <= '0;
      alu.alu_a      <= '0;
      alu.alu_b      <= '0;
      ir_op          <= '0;
      ir_rd          <= '0;
      seen_low       <= 1'b0;
      cnt            <= '0;
      cap_acc1       <= '0;
      cap_acc2       <= '0;
      cap_flags      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (host_wr) rf[host_addr] <= host_wdata;
          if (instr_valid) begin
            if (!legal) begin
              err <= 1'b1;
            end else begin
              ir_op <= op;
              ir_rd <= rd;
              if (op == OP_NOP) begin
                state <= WB;
              end else begin
                state          <= ISSUE;
                alu.alu_bgn    <= 1'b1;
                alu.alu_opcode <= {1'b0, op};
                alu.alu_a      <= rd_val;
                alu.alu_b      <= instr[4] ? {12'b0, instr[3:0]} : rs_val;
              end
            end
          end
        end
        ISSUE: begin
          alu.alu_bgn <= 1'b0;
          seen_low    <= 1'b0;
          cnt         <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // rdy is a level that idles high; only a rising return after a low counts.
          if (alu.alu_rdy && seen_low) begin
            cap_acc1  <= alu.alu_acc1;
            cap_acc2  <= alu.alu_acc2;
            cap_flags <= {alu.alu_zero, alu.alu_negative, alu.alu_carry, alu.alu_overflow};
            state     <= WB;
          end else begin
            if (!alu.alu_rdy) seen_low <= 1'b1;
            if (cnt == TW'(TIMEOUT - 1)) begin
              err            <= 1'b1;
              alu.alu_opcode <= '0;
              state          <= IDLE;
            end
          end
        end
        WB: begin
          if (ir_op != OP_NOP) flags <= cap_flags;
          unique case (ir_op)
            OP_MUL: begin
              rf[ir_rd]        <= cap_acc1;
              rf[ir_rd + 3'd1] <= cap_acc2;
            end
            OP_CMP, OP_TST, OP_NOP: ;
            default: rf[ir_rd] <= cap_acc1;
          endcase
          alu.alu_opcode <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU responder.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic        host_wr = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic [3:0]  flags;
  logic        busy, done, err;

  alu_issue_ctrl_if alu();

  alu_issue_ctrl #(.TIMEOUT(64), .TW(7)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .alu(alu.master),
    .flags(flags), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ALU model: drops rdy the cycle after bgn, raises it three cycles later.
  logic        m_stale = 1'b0;
  logic        m_rdy   = 1'b1;
  logic [15:0] m_acc1  = '0, m_acc2 = '0;
  logic [3:0]  m_flags = '0;
  int          mcnt    = 0;

  assign alu.alu_rdy      = m_rdy;
  assign alu.alu_acc1     = m_acc1;
  assign alu.alu_acc2     = m_acc2;
  assign alu.alu_zero     = m_flags[3];
  assign alu.alu_negative = m_flags[2];
  assign alu.alu_carry    = m_flags[1];
  assign alu.alu_overflow = m_flags[0];

  always @(posedge clk) begin
    if (alu.alu_bgn) begin
      if (!m_stale) begin
        m_rdy <= 1'b0;
        mcnt  <= 3;
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) m_rdy <= 1'b1;
    end
  end

  int bgn_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (alu.alu_bgn) bgn_cnt <= bgn_cnt + 1;
    if (done)        done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d);
    host_wr = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    host_addr = a;
    #1;
    chk(tag, {16'b0, host_rdata}, {16'b0, exp});
  endtask

  task automatic issue(input logic [15:0] i);
    instr_valid = 1'b1; instr = i;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!instr_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_bound", {31'b0, instr_ready}, 32'd1);
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic ui, input logic [3:0] imm);
    return {op, rd, rs, ui, imm};
  endfunction

  int n, b0, d0;

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_bgn",   {31'b0, alu.alu_bgn}, 32'd0);
    rd_chk("rst_r0", 3'd0, 16'h0000);

    // ADD R1,R2 : 5 + 3
    host_write(3'd1, 16'h0005);
    host_write(3'd2, 16'h0003);
    rd_chk("hw_r1", 3'd1, 16'h0005);
    m_acc1 = 16'h0008; m_acc2 = 16'h0; m_flags = 4'b0000;
    b0 = bgn_cnt; d0 = done_cnt;
    issue(mk(5'h01, 3'd1, 3'd2, 1'b0, 4'h0));
    chk("add_bgn", {31'b0, alu.alu_bgn}, 32'd1);
    chk("add_a",   {16'b0, alu.alu_a}, 32'h5);
    chk("add_b",   {16'b0, alu.alu_b}, 32'h3);
    chk("add_op",  {26'b0, alu.alu_opcode}, 32'h01);
    tick();
    chk("add_bgn_pulse", {31'b0, alu.alu_bgn}, 32'd0);
    wait_ready(n);
    chk("add_lat", n, 32'd5);
    chk("add_bgn_cnt",  bgn_cnt - b0, 32'd1);
    chk("add_done_cnt", done_cnt - d0, 32'd1);
    chk("add_busy", {31'b0, busy}, 32'd0);
    rd_chk("add_r1", 3'd1, 16'h0008);

    // MUL R7, #8 : result pair wraps into R0
    host_write(3'd7, 16'h0100);
    host_write(3'd0, 16'h1234);
    m_acc1 = 16'h0800; m_acc2 = 16'h0000;
    issue(mk(5'h08, 3'd7, 3'd0, 1'b1, 4'h8));
    chk("mul_a",  {16'b0, alu.alu_a}, 32'h0100);
    chk("mul_b",  {16'b0, alu.alu_b}, 32'h0008);
    chk("mul_op", {26'b0, alu.alu_opcode}, 32'h08);
    wait_ready(n);
    rd_chk("mul_r7", 3'd7, 16'h0800);
    rd_chk("mul_r0", 3'd0, 16'h0000);
    rd_chk("mul_r1", 3'd1, 16'h0008);
    rd_chk("mul_r2", 3'd2, 16'h0003);
    chk("mul_opclr", {26'b0, alu.alu_opcode}, 32'h0);

    // CMP: flags only
    m_acc1 = 16'hBEEF; m_flags = 4'b1000;
    d0 = done_cnt;
    issue(mk(5'h0F, 3'd1, 3'd2, 1'b0, 4'h0));
    wait_ready(n);
    rd_chk("cmp_r1", 3'd1, 16'h0008);
    chk("cmp_flags", {28'b0, flags}, 32'b1000);
    chk("cmp_done", done_cnt - d0, 32'd1);

    // NOP: done without ALU, flags kept
    m_flags = 4'b0101;
    b0 = bgn_cnt; d0 = done_cnt;
    issue(mk(5'h1F, 3'd1, 3'd2, 1'b0, 4'h0));
    chk("nop_done_now", {31'b0, done}, 32'd1);
    wait_ready(n);
    chk("nop_bgn", bgn_cnt - b0, 32'd0);
    chk("nop_done", done_cnt - d0, 32'd1);
    chk("nop_flags", {28'b0, flags}, 32'b1000);
    rd_chk("nop_r1", 3'd1, 16'h0008);

    // host write in the accept cycle is seen by the operands
    m_acc1 = 16'h000E; m_flags = 4'b0010;
    host_wr = 1'b1; host_addr = 3'd3; host_wdata = 16'h0007;
    issue(mk(5'h01, 3'd3, 3'd3, 1'b0, 4'h0));
    host_wr = 1'b0;
    chk("fwd_a", {16'b0, alu.alu_a}, 32'h7);
    chk("fwd_b", {16'b0, alu.alu_b}, 32'h7);
    wait_ready(n);
    rd_chk("fwd_r3", 3'd3, 16'h000E);
    chk("fwd_flags", {28'b0, flags}, 32'b0010);

    // host write outside IDLE is dropped
    issue(mk(5'h01, 3'd4, 3'd4, 1'b0, 4'h0));
    host_write(3'd5, 16'hAAAA);
    wait_ready(n);
    rd_chk("busy_hw", 3'd5, 16'h0000);

    // illegal opcode
    b0 = bgn_cnt; d0 = done_cnt;
    issue(mk(5'h15, 3'd1, 3'd2, 1'b0, 4'h0));
    chk("ill_err",   {31'b0, err}, 32'd1);
    chk("ill_ready", {31'b0, instr_ready}, 32'd1);
    tick(); tick();
    chk("ill_bgn",  bgn_cnt - b0, 32'd0);
    chk("ill_done", done_cnt - d0, 32'd0);

    // stale rdy -> timeout
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_err", {31'b0, err}, 32'd0);
    host_write(3'd1, 16'h0011);
    m_stale = 1'b1;
    d0 = done_cnt;
    issue(mk(5'h01, 3'd1, 3'd2, 1'b0, 4'h0));
    wait_ready(n);
    chk("to_cycles", n, 32'd65);
    chk("to_err",  {31'b0, err}, 32'd1);
    chk("to_done", done_cnt - d0, 32'd0);
    chk("to_op",   {26'b0, alu.alu_opcode}, 32'h0);
    rd_chk("to_r1", 3'd1, 16'h0011);
    m_stale = 1'b0;

    // reset in WAIT aborts the op
    rst = 1'b1; tick(); rst = 1'b0;
    host_write(3'd1, 16'h0055);
    host_write(3'd2, 16'h0001);
    m_acc1 = 16'h0056;
    d0 = done_cnt;
    issue(mk(5'h01, 3'd1, 3'd2, 1'b0, 4'h0));
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_bgn",  {31'b0, alu.alu_bgn}, 32'd0);
    chk("mrst_op",   {26'b0, alu.alu_opcode}, 32'h0);
    rd_chk("mrst_r1", 3'd1, 16'h0000);
    rd_chk("mrst_r2", 3'd2, 16'h0000);
    repeat (6) tick();
    chk("mrst_done", done_cnt - d0, 32'd0);
    rd_chk("mrst_r1_late", 3'd1, 16'h0000);
    chk("mrst_busy_late", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
